// File: rtl/aes256_key_expand_pkg.sv
// Shared constants, FSM encoding and round-constant table
// for the iterative AES-256 key schedule.
package aes256_key_expand_pkg;

  localparam int NK     = 8;
  localparam int NR     = 14;
  localparam int NWORDS = 4 * (NR + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  // Rcon[j] for j = i/8; only 1..7 occur for Nk=8.
  function automatic logic [7:0] rcon(input logic [2:0] j);
    logic [7:0] r;
    r = 8'h00;
    unique case (j)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes256_key_expand_sbox.sv
// Forward AES S-box, one byte, purely combinational.
// Four instances form SubWord in the key schedule.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key expansion: one schedule word per
// cycle into a 60-word store, round keys read by index.
module aes256_key_expand
  import aes256_key_expand_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [255:0] i_key,
  input  logic [3:0]   i_rk_idx,
  output logic [127:0] o_round_key,
  output logic         o_busy,
  output logic         o_valid,
  output logic         o_done
);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] w_q [NWORDS];
  logic        busy_q;
  logic        valid_q;
  logic        done_q;

  logic [5:0]  prev_idx;
  logic [5:0]  back_idx;
  logic [31:0] prev_w;
  logic [31:0] back_w;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] w_d;

  // Operand fetch: w[i-1] and w[i-8]; RotWord only on i%8==0.
  always_comb begin
    prev_idx = (cnt_q == 6'd0) ? 6'd0 : cnt_q - 6'd1;
    back_idx = cnt_q - 6'd8;
    prev_w   = w_q[prev_idx];
    back_w   = w_q[back_idx];
    if (cnt_q[2:0] == 3'd0) begin
      sub_in = {prev_w[23:0], prev_w[31:24]};
    end else begin
      sub_in = prev_w;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .byte_i (sub_in[8*b +: 8]),
      .byte_o (sub_out[8*b +: 8])
    );
  end

  // Schedule word selection by position in the 8-word period.
  always_comb begin
    temp = prev_w;
    unique case (cnt_q[2:0])
      3'd0:    temp = sub_out ^ {rcon(cnt_q[5:3]), 24'h0};
      3'd4:    temp = sub_out;
      default: temp = prev_w;
    endcase
    w_d = back_w ^ temp;
  end

  // FSM, word counter and schedule store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NWORDS; k++) begin
        w_q[k] <= 32'h0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            for (int k = 0; k < NK; k++) begin
              w_q[k] <= i_key[255 - 32*k -: 32];
            end
            cnt_q   <= 6'd8;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          w_q[cnt_q] <= w_d;
          if (cnt_q == 6'(NWORDS - 1)) begin
            cnt_q   <= 6'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [5:0] rd_base;

  // Combinational round-key read; indices past NR read zero.
  always_comb begin
    rd_base     = {i_rk_idx, 2'b00};
    o_round_key = 128'h0;
    if (i_rk_idx <= 4'(NR)) begin
      o_round_key = {w_q[rd_base],
                     w_q[rd_base + 6'd1],
                     w_q[rd_base + 6'd2],
                     w_q[rd_base + 6'd3]};
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed + random bench for aes256_key_expand against a
// reference schedule built from GF(2^8) arithmetic.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [255:0] i_key;
  logic [3:0]   i_rk_idx;
  logic [127:0] o_round_key;
  logic         o_busy;
  logic         o_valid;
  logic         o_done;

  int tests = 0;
  int fails = 0;

  logic [7:0]  sbox_tab [256];
  logic [31:0] ref_w [60];

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes256_key_expand dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_key       (i_key),
    .i_rk_idx    (i_rk_idx),
    .o_round_key (o_round_key),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
                    rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]],
            sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int k = 0; k < 8; k++) ref_w[k] = key[255 - 32*k -: 32];
    for (int i = 8; i < 60; i++) begin
      t = ref_w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      ref_w[i] = ref_w[i-8] ^ t;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads all 16 indices; DUT must be idle so crossing edges is harmless.
  task automatic check_all(input logic [255:0] key, input string tag);
    logic [127:0] exp;
    ref_expand(key);
    for (int r = 0; r < 16; r++) begin
      i_rk_idx = 4'(r);
      #1;
      exp = (r < 15) ? {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]}
                     : 128'h0;
      chk($sformatf("%s_rk%0d", tag, r), o_round_key, exp);
    end
  endtask

  // Called just after the accepting edge; returns edges until o_done.
  task automatic wait_done(output int cyc, output bit busy_bad);
    cyc = 0;
    busy_bad = 1'b0;
    while (!o_done && cyc < 200) begin
      if (!o_busy) busy_bad = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic run_key(input logic [255:0] key, input string tag);
    int cyc;
    bit bb;
    i_key = key;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(cyc, bb);
    chk({tag, "_lat"}, 128'(cyc), 128'd52);
    chk({tag, "_busy"}, 128'(bb), 128'd0);
    chk({tag, "_flags"}, {125'd0, o_busy, o_valid, o_done}, 128'b011);
    check_all(key, tag);
  endtask

  initial begin
    logic [255:0] k1, k2, k3;
    int cyc, dones, done_at;
    bit bb;

    rst = 1'b1;
    i_start = 1'b0;
    i_key = '0;
    i_rk_idx = 4'd0;
    build_sbox();
    repeat (3) tick();
    chk("rst_flags", {125'd0, o_busy, o_valid, o_done}, 128'd0);
    chk("rst_rk0", o_round_key, 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 A.3 known answers
    run_key(KEY_A3, "a3");
    i_rk_idx = 4'd0; #1;
    chk("a3_kat0", o_round_key, 128'h603deb1015ca71be2b73aef0857d7781);
    i_rk_idx = 4'd1; #1;
    chk("a3_kat1", o_round_key, 128'h1f352c073b6108d72d9810a30914dff4);
    i_rk_idx = 4'd2; #1;
    chk("a3_kat2", o_round_key, 128'h9ba354118e6925afa51a8b5f2067fcde);
    i_rk_idx = 4'd14; #1;
    chk("a3_kat14", o_round_key, 128'hfe4890d1e6188d0b046df344706c631e);
    i_rk_idx = 4'd15; #1;
    chk("a3_kat15", o_round_key, 128'h0);

    // i_start held and i_key scrambled during expansion
    k1 = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom};
    i_key = k1;
    i_start = 1'b1;
    tick();
    dones = 0;
    done_at = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c <= 40) begin
        i_key = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
      end else begin
        i_start = 1'b0;
      end
      tick();
      if (o_done) begin
        dones++;
        done_at = c;
      end
    end
    chk("hold_dones", 128'(dones), 128'd1);
    chk("hold_at", 128'(done_at), 128'd52);
    chk("hold_valid", 128'(o_valid), 128'd1);
    check_all(k1, "hold");

    // async reset mid-expansion
    i_key = KEY_A3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (19) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_flags", {125'd0, o_busy, o_valid, o_done}, 128'd0);
    i_rk_idx = 4'd1; #1;
    chk("mrst_rk1", o_round_key, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    run_key(KEY_A3, "a3b");

    // back-to-back start on the o_done cycle
    k2 = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom};
    k3 = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom};
    i_key = k2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(cyc, bb);
    chk("b2b_lat1", 128'(cyc), 128'd52);
    i_key = k3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("b2b_accept", {125'd0, o_busy, o_valid, o_done}, 128'b100);
    i_key = k2;
    wait_done(cyc, bb);
    chk("b2b_lat2", 128'(cyc), 128'd52);
    chk("b2b_busy", 128'(bb), 128'd0);
    check_all(k3, "b2b");

    // random keys
    for (int n = 0; n < 4; n++) begin
      run_key({$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom},
              $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
